alu_yz_stage: RTL and testbench

ALU_YZ_STAGE -- requirements
Module: alu_yz_stage

---
 rtl/alu_yz_stage.sv | 146 ++++++++++++++
 tb/tb_alu_yz_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_yz_stage.sv
// Operand/result staging around the ALU: Y and B operand registers, latched opcode, and the Z
// result register, sequenced by an IDLE/EXEC/WAIT/DONE controller with a multi-cycle timeout.
module alu_yz_stage #(
  parameter logic [4:0]  OP_MUL  = 5'd15,
  parameter logic [4:0]  OP_DIV  = 5'd16,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] bus_in,
  input  logic        y_in,
  input  logic        start,
  input  logic [4:0]  opcode,
  output logic [31:0] y_out,
  output logic [31:0] b_out,
  output logic [4:0]  op_out,
  input  logic [63:0] alu_result,
  input  logic        alu_done,
  output logic [31:0] z_high_out,
  output logic [31:0] z_low_out,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        neg,
  output logic        timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     b_q, b_d;
  logic [4:0]      op_q, op_d;
  logic [31:0]     zh_q, zh_d;
  logic [31:0]     zl_q, zl_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic            te_q, te_d;
  logic            is_multi;

  assign is_multi = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    zh_d    = zh_q;
    zl_d    = zl_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    te_d    = te_q;

    // Y may only change while the operand is not being consumed by an ALU unit.
    if (y_in && (state_q == StIdle || state_q == StDone)) begin
      y_d = bus_in;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          b_d     = bus_in;
          op_d    = opcode;
          te_d    = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_multi) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          zh_d    = '0;
          zl_d    = alu_result[31:0];
          zero_d  = (alu_result[31:0] == 32'h0);
          neg_d   = alu_result[31];
          state_d = StDone;
        end
      end
      StWait: begin
        // Completion beats timeout when both land in the same cycle.
        if (alu_done) begin
          zh_d    = alu_result[63:32];
          zl_d    = alu_result[31:0];
          zero_d  = (alu_result == 64'h0);
          neg_d   = alu_result[63];
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          te_d    = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      y_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      zh_q    <= '0;
      zl_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      b_q     <= b_d;
      op_q    <= op_d;
      zh_q    <= zh_d;
      zl_q    <= zl_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      te_q    <= te_d;
    end
  end

  assign y_out       = y_q;
  assign b_out       = b_q;
  assign op_out      = op_q;
  assign z_high_out  = zh_q;
  assign z_low_out   = zl_q;
  assign zero        = zero_q;
  assign neg         = neg_q;
  assign timeout_err = te_q;
  assign busy        = (state_q == StExec) || (state_q == StWait);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_alu_yz_stage.sv
// Self-checking bench for alu_yz_stage: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_alu_yz_stage;

  localparam logic [4:0] OpMul = 5'd15;
  localparam logic [4:0] OpDiv = 5'd16;
  localparam logic [4:0] OpRol = 5'd3;
  localparam int         ToCyc = 40;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] bus_in = '0;
  logic        y_in = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] y_out, b_out;
  logic [4:0]  op_out;
  logic [63:0] alu_result = '0;
  logic        alu_done = 1'b0;
  logic [31:0] z_high_out, z_low_out;
  logic        busy, done, zero, neg, timeout_err;

  int checks = 0;
  int errors = 0;

  // Model state: last committed Z and flags.
  logic [63:0] m_z = '0;
  logic        m_zero = 1'b0;
  logic        m_neg = 1'b0;

  alu_yz_stage #(.OP_MUL(OpMul), .OP_DIV(OpDiv), .TIMEOUT(ToCyc)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .y_in(y_in), .start(start), .opcode(opcode),
    .y_out(y_out), .b_out(b_out), .op_out(op_out), .alu_result(alu_result),
    .alu_done(alu_done), .z_high_out(z_high_out), .z_low_out(z_low_out), .busy(busy),
    .done(done), .zero(zero), .neg(neg), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [31:0] b;
    logic [4:0]  op;
    logic [63:0] r;
    int          d;
    logic [63:0] ez;
    logic        ezero;
    logic        eneg;
    logic        ete;
    int          elat;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y"}, 64'(y_out), 64'h0);
    chk({tag, "_b"}, 64'(b_out), 64'h0);
    chk({tag, "_op"}, 64'(op_out), 64'h0);
    chk({tag, "_z"}, {z_high_out, z_low_out}, 64'h0);
    chk({tag, "_flags"}, 64'({busy, done, zero, neg, timeout_err}), 64'h0);
  endtask

  // Expected outcome of one transaction, from the operation's rules alone.
  task automatic model(input logic [4:0] op, input logic [63:0] r, input int d,
                       output logic [63:0] ez, output logic ezero, output logic eneg,
                       output logic ete, output int elat);
    if (op != OpMul && op != OpDiv) begin
      ez = {32'h0, r[31:0]}; ezero = (r[31:0] == 0); eneg = r[31]; ete = 1'b0; elat = 1;
    end else if (d <= ToCyc) begin
      ez = r; ezero = (r == 0); eneg = r[63]; ete = 1'b0; elat = d + 1;
    end else begin
      ez = m_z; ezero = m_zero; eneg = m_neg; ete = 1'b1; elat = ToCyc + 1;
    end
  endtask

  // d = WAIT cycle (1-based) in which alu_done is raised; ignored for single-cycle ops.
  task automatic run_op(input vec_t v);
    int  lat = 0;
    int  busy_n = 0;
    bit  got = 0;
    y_in = 1'b1; bus_in = v.y;
    step();
    y_in = 1'b0;
    bus_in = v.b; opcode = v.op; start = 1'b1;
    step();
    start = 1'b0; bus_in = $urandom; opcode = 5'($urandom);
    chk("te_clear_on_start", 64'(timeout_err), 64'h0);
    for (int i = 1; i <= 60 && !got; i++) begin
      if (busy) busy_n++;
      alu_result = v.r;
      alu_done = (i == 1) ? 1'($urandom) : (i - 1 == v.d);
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; y_in = 1'b1; bus_in = $urandom; opcode = 5'($urandom);
      end
      step();
      start = 1'b0; y_in = 1'b0; alu_done = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("done_seen", 64'(got), 64'h1);
    chk("latency", 64'(lat), 64'(v.elat));
    chk("busy_cycles", 64'(busy_n), 64'(v.elat));
    chk("z", {z_high_out, z_low_out}, v.ez);
    chk("zero", 64'(zero), 64'(v.ezero));
    chk("neg", 64'(neg), 64'(v.eneg));
    chk("timeout_err", 64'(timeout_err), 64'(v.ete));
    chk("y_out", 64'(y_out), 64'(v.y));
    chk("b_out", 64'(b_out), 64'(v.b));
    chk("op_out", 64'(op_out), 64'(v.op));
    step();
    chk("done_pulse", 64'({done, busy}), 64'h0);
    m_z = v.ez; m_zero = v.ezero; m_neg = v.eneg;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{32'h8000_0001, 32'h4, OpRol, 64'h18, 0, 64'h18, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{32'h5, 32'h7, OpMul, 64'h1_0000_0000, 5, 64'h1_0000_0000, 1'b0, 1'b0, 1'b0, 6};
    vecs[2] = '{32'h9, 32'h3, OpDiv, 64'hDEAD_BEEF_CAFE_F00D, 99, 64'h1_0000_0000,
                1'b0, 1'b0, 1'b1, 41};
    vecs[3] = '{32'h1, 32'h2, OpRol, 64'h1234_5678_FFFF_FFF0, 0, 64'hFFFF_FFF0,
                1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{32'h1, 32'h2, 5'd0, 64'hFFFF_FFFF_0000_0000, 0, 64'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h3, 32'h4, OpMul, 64'h8000_0000_0000_0000, 40, 64'h8000_0000_0000_0000,
                1'b0, 1'b1, 1'b0, 41};
    vecs[6] = '{32'h6, 32'h8, OpDiv, 64'h0, 39, 64'h0, 1'b1, 1'b0, 1'b0, 40};
    vecs[7] = '{32'h7, 32'h9, OpDiv, 64'h8000_0000, 1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 2};
    vecs[8] = '{32'hA, 32'hB, OpDiv, 64'h5, 41, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 41};

    step();
    step();
    clr = 1'b0;
    chk_all_zero("reset");

    foreach (vecs[i]) run_op(vecs[i]);

    // y_in and start together in IDLE; then start/y_in presented during DONE.
    y_in = 1'b1; start = 1'b1; bus_in = 32'h1357_9BDF; opcode = OpRol;
    step();
    y_in = 1'b0; start = 1'b0; alu_result = 64'h42;
    chk("same_cycle_y", 64'(y_out), 64'h1357_9BDF);
    chk("same_cycle_b", 64'(b_out), 64'h1357_9BDF);
    step();
    chk("same_cycle_done", 64'(done), 64'h1);
    y_in = 1'b1; start = 1'b1; bus_in = 32'h2468_ACE0; opcode = OpMul;
    step();
    y_in = 1'b0; start = 1'b0;
    chk("done_start_ignored", 64'(busy), 64'h0);
    chk("done_b_kept", 64'(b_out), 64'h1357_9BDF);
    chk("done_y_loaded", 64'(y_out), 64'h2468_ACE0);
    m_z = 64'h42; m_zero = 1'b0; m_neg = 1'b0;

    // clr in WAIT cycle 3, then a late alu_done.
    bus_in = 32'h77; opcode = OpDiv; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_clr_busy", 64'(busy), 64'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all_zero("clr_mid_wait");
    alu_result = 64'hFFFF_0000_FFFF_0000; alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk_all_zero("late_done");
    m_z = '0; m_zero = 1'b0; m_neg = 1'b0;

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      v.y = $urandom;
      v.b = $urandom;
      v.op = (sel == 0) ? OpMul : (sel == 1) ? OpDiv : 5'($urandom_range(0, 31));
      if (sel == 2 && (v.op == OpMul || v.op == OpDiv)) v.op = 5'd1;
      v.r = ($urandom_range(0, 7) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
      v.d = $urandom_range(1, 44);
      model(v.op, v.r, v.d, v.ez, v.ezero, v.eneg, v.ete, v.elat);
      run_op(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
